// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and width definitions for the ALU issue controller.
package alu_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_ADDA = 3'b101;
  localparam logic [2:0] OP_ANDA = 3'b110;
  localparam logic [2:0] OP_ORA  = 3'b111;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ISSUE  = 2'b01;
  localparam logic [1:0] ST_WAIT   = 2'b10;
  localparam logic [1:0] ST_RETIRE = 2'b11;

  // The write-to-A opcodes take operand A from the accumulator.
  function automatic logic uses_acc(input logic [2:0] op);
    logic r;
    case (op)
      OP_ADDA, OP_ANDA, OP_ORA: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding packed {opcode, A, B} entries.
// Occupancy is registered, so a pushed entry is visible the cycle after the push.
module alu_cmd_fifo #(
  parameter int DW    = 35,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered requester commands to the ALU one at a time and returns results,
// chaining the write-to-A opcodes on an accumulator of the previous result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [2:0]       In_Opcode,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic             Alu_Valid,
  input  logic             Alu_Ready,
  output logic [2:0]       Alu_Opcode,
  output logic [WIDTH-1:0] Alu_A,
  output logic [WIDTH-1:0] Alu_B,
  input  logic             Alu_Done,
  input  logic [WIDTH-1:0] Alu_Result,
  input  logic             Alu_CF,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [2:0]       Out_Opcode,
  output logic [WIDTH-1:0] Out_Result,
  output logic             Out_CF,
  output logic [CW-1:0]    Count
);

  localparam int DW = 3 + 2 * WIDTH;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] acc_r;
  logic             alu_valid_r;
  logic [2:0]       alu_op_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic             out_valid_r;
  logic [2:0]       out_op_r;
  logic [WIDTH-1:0] out_result_r;
  logic             out_cf_r;

  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [DW-1:0]    head_s;
  logic [2:0]       head_op_s;
  logic [WIDTH-1:0] head_a_s;
  logic [WIDTH-1:0] head_b_s;

  assign In_Ready  = ~fifo_full_s;
  assign push_s    = In_Valid & ~fifo_full_s;
  assign pop_s     = (state_r == ST_IDLE) & Enable & ~fifo_empty_s;
  assign head_op_s = head_s[DW-1 -: 3];
  assign head_a_s  = head_s[2*WIDTH-1 -: WIDTH];
  assign head_b_s  = head_s[WIDTH-1:0];

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({In_Opcode, In_A, In_B}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (Count)
  );

  // Issue FSM; NOPs are popped in IDLE without touching the ALU or the accumulator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      acc_r        <= {WIDTH{1'b0}};
      alu_valid_r  <= 1'b0;
      alu_op_r     <= 3'b000;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      out_op_r     <= 3'b000;
      out_result_r <= {WIDTH{1'b0}};
      out_cf_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s && (head_op_s != OP_NOP)) begin
            alu_op_r    <= head_op_s;
            alu_a_r     <= uses_acc(head_op_s) ? acc_r : head_a_s;
            alu_b_r     <= head_b_s;
            alu_valid_r <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (Alu_Ready) begin
            alu_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (Alu_Done) begin
            out_result_r <= Alu_Result;
            acc_r        <= Alu_Result;
            out_cf_r     <= Alu_CF;
            out_op_r     <= alu_op_r;
            out_valid_r  <= 1'b1;
            state_r      <= ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          if (Out_Ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          alu_valid_r <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign Alu_Valid  = alu_valid_r;
  assign Alu_Opcode = alu_op_r;
  assign Alu_A      = alu_a_r;
  assign Alu_B      = alu_b_r;
  assign Out_Valid  = out_valid_r;
  assign Out_Opcode = out_op_r;
  assign Out_Result = out_result_r;
  assign Out_CF     = out_cf_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model and a behavioural ALU responder.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Enable = 1'b0;
  logic In_Valid = 1'b0;
  logic In_Ready;
  logic [2:0] In_Opcode = 3'b000;
  logic [WIDTH-1:0] In_A = 16'h0000;
  logic [WIDTH-1:0] In_B = 16'h0000;
  logic Alu_Valid;
  logic Alu_Ready = 1'b0;
  logic [2:0] Alu_Opcode;
  logic [WIDTH-1:0] Alu_A;
  logic [WIDTH-1:0] Alu_B;
  logic Alu_Done = 1'b0;
  logic [WIDTH-1:0] Alu_Result = 16'h0000;
  logic Alu_CF = 1'b0;
  logic Out_Valid;
  logic Out_Ready = 1'b0;
  logic [2:0] Out_Opcode;
  logic [WIDTH-1:0] Out_Result;
  logic Out_CF;
  logic [CW-1:0] Count;

  alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Opcode(In_Opcode), .In_A(In_A), .In_B(In_B),
    .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Opcode(Alu_Opcode), .Alu_A(Alu_A), .Alu_B(Alu_B),
    .Alu_Done(Alu_Done), .Alu_Result(Alu_Result), .Alu_CF(Alu_CF),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Opcode(Out_Opcode),
    .Out_Result(Out_Result), .Out_CF(Out_CF), .Count(Count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [34:0] exp_issue [$];
  logic [19:0] exp_out [$];
  logic [15:0] m_acc = 16'h0000;
  int alu_hs_cnt = 0;
  int out_hs_cnt = 0;
  bit alu_hs_flag = 1'b0;
  logic [2:0] hs_op;
  logic [15:0] hs_a, hs_b;
  bit alu_busy = 1'b0;
  int alu_delay = 0;
  bit hold_done = 1'b1;
  int out_rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // ALU behaviour: returns {carry, result}.
  function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b001, 3'b101: return {1'b0, a} + {1'b0, b};
      3'b010, 3'b110: return {1'b0, a & b};
      3'b011, 3'b111: return {1'b0, a | b};
      3'b100:         return {16'h0000, (a < b)};
      default:        return 17'h00000;
    endcase
  endfunction

  task automatic model_push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ae;
    logic [16:0] r;
    if (op != 3'b000) begin
      ae = (op inside {3'b101, 3'b110, 3'b111}) ? m_acc : a;
      r = alu_ref(op, ae, b);
      exp_issue.push_back({op, ae, b});
      exp_out.push_back({op, r[16], r[15:0]});
      m_acc = r[15:0];
    end
  endtask

  // Caller is just after a rising edge; returns just after the edge that pushed (or not).
  task automatic push_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output bit accepted);
    In_Valid = 1'b1; In_Opcode = op; In_A = a; In_B = b;
    @(negedge CLK);
    accepted = In_Ready;
    @(posedge CLK); #1;
    In_Valid = 1'b0;
    if (accepted) model_push(op, a, b);
  endtask

  task automatic do_reset(input int cycles);
    hold_done = 1'b1;
    RST = 1'b1;
    repeat (cycles) @(posedge CLK);
    #1; RST = 1'b0;
    #1;
    alu_busy = 1'b0; alu_hs_flag = 1'b0; Alu_Done = 1'b0;
    exp_issue.delete(); exp_out.delete();
    m_acc = 16'h0000;
    hold_done = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    Enable = 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge CLK);
      if (exp_issue.size() == 0 && exp_out.size() == 0 && Count == 3'd0 && !Out_Valid && !Alu_Valid)
        done = 1'b1;
    end
    check("drain_timeout", {63'd0, done}, 64'd1);
    @(posedge CLK); #1;
  endtask

  // Monitor: scoreboard pops on each ALU and Out handshake, plus hold-stability checks.
  initial begin : monitor
    bit pv_alu, pv_out, p_rst;
    logic [34:0] p_alu;
    logic [19:0] p_out;
    logic [34:0] e_i;
    logic [19:0] e_o;
    pv_alu = 1'b0; pv_out = 1'b0; p_rst = 1'b1; p_alu = '0; p_out = '0;
    forever begin
      @(negedge CLK);
      if (pv_alu && !p_rst)
        check("alu_hold", {Alu_Valid, Alu_Opcode, Alu_A, Alu_B}, {1'b1, p_alu});
      if (pv_out && !p_rst)
        check("out_hold", {Out_Valid, Out_Opcode, Out_CF, Out_Result}, {1'b1, p_out});
      if (Alu_Valid === 1'b1 && Alu_Ready && !RST) begin
        alu_hs_cnt++;
        hs_op = Alu_Opcode; hs_a = Alu_A; hs_b = Alu_B;
        alu_hs_flag = 1'b1;
        if (exp_issue.size() == 0) begin
          check("alu_unexpected", {Alu_Opcode, Alu_A, Alu_B}, 64'd0 - 64'd1);
        end else begin
          e_i = exp_issue.pop_front();
          check("alu_issue", {Alu_Opcode, Alu_A, Alu_B}, e_i);
        end
      end
      if (Out_Valid === 1'b1 && Out_Ready && !RST) begin
        out_hs_cnt++;
        if (exp_out.size() == 0) begin
          check("out_unexpected", {Out_Opcode, Out_CF, Out_Result}, 64'd0 - 64'd1);
        end else begin
          e_o = exp_out.pop_front();
          check("out_result", {Out_Opcode, Out_CF, Out_Result}, e_o);
        end
      end
      if (Out_Valid === 1'b1)
        check("one_in_flight", {63'd0, Alu_Valid}, 64'd0);
      pv_alu = (Alu_Valid === 1'b1) && !Alu_Ready;
      p_alu  = {Alu_Opcode, Alu_A, Alu_B};
      pv_out = (Out_Valid === 1'b1) && !Out_Ready;
      p_out  = {Out_Opcode, Out_CF, Out_Result};
      p_rst  = RST;
    end
  end

  // ALU responder: random ready, random done latency, stray done strobes while unaccepted.
  initial begin : alu_model
    logic [16:0] r;
    forever begin
      @(posedge CLK); #1;
      Alu_Done = 1'b0;
      if (alu_hs_flag) begin
        alu_hs_flag = 1'b0;
        alu_busy = 1'b1;
        alu_delay = $urandom_range(1, 3);
      end
      if (alu_busy && !hold_done) begin
        alu_delay--;
        if (alu_delay <= 0) begin
          r = alu_ref(hs_op, hs_a, hs_b);
          Alu_Result = r[15:0]; Alu_CF = r[16]; Alu_Done = 1'b1;
          alu_busy = 1'b0;
        end
      end
      Alu_Ready = ($urandom_range(0, 2) != 0);
      if (!alu_busy && !hold_done && Alu_Valid === 1'b1 && !Alu_Ready && $urandom_range(0, 2) == 0) begin
        Alu_Result = 16'($urandom); Alu_CF = 1'b1; Alu_Done = 1'b1;
      end
    end
  end

  initial begin : out_ready_drv
    forever begin
      @(posedge CLK); #1;
      case (out_rdy_mode)
        1:       Out_Ready = 1'b0;
        2:       Out_Ready = 1'b1;
        default: Out_Ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit acc;
    int n0, m0;
    logic [2:0] op;
    logic [15:0] a, b;
    bit seen;

    // Reset state
    @(posedge CLK); #1;
    do_reset(2);
    check("rst_in_ready", {63'd0, In_Ready}, 64'd1);
    check("rst_count", {61'd0, Count}, 64'd0);
    check("rst_alu", {Alu_Valid, Alu_Opcode, Alu_A, Alu_B}, 64'd0);
    check("rst_out", {Out_Valid, Out_Opcode, Out_CF, Out_Result}, 64'd0);

    // Basic issue with latency
    Enable = 1'b1;
    push_cmd(3'b001, 16'h0003, 16'h0004, acc);
    check("push_add", {63'd0, acc}, 64'd1);
    check("lat_count1", {61'd0, Count}, 64'd1);
    check("lat_valid1", {63'd0, Alu_Valid}, 64'd0);
    @(posedge CLK); #1;
    check("lat_valid2", {63'd0, Alu_Valid}, 64'd1);
    check("lat_issue", {Alu_Opcode, Alu_A, Alu_B}, {3'b001, 16'h0003, 16'h0004});
    wait_drain();

    // Accumulator chaining
    push_cmd(3'b001, 16'hFFFF, 16'h0001, acc);
    push_cmd(3'b101, 16'h1234, 16'h0005, acc);
    wait_drain();

    // Full FIFO, then release with a push in the pop cycle
    Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(3'(1 + (i % 4)), 16'(16'h0100 + i), 16'(16'h0010 * i), acc);
      check("full_accept", {63'd0, acc}, {63'd0, (i < 4)});
    end
    check("full_count", {61'd0, Count}, 64'd4);
    check("full_in_ready", {63'd0, In_Ready}, 64'd0);
    Enable = 1'b1;
    push_cmd(3'b011, 16'hAAAA, 16'h5555, acc);
    check("full_pop_no_push", {63'd0, acc}, 64'd0);
    wait_drain();

    // NOP is dropped
    n0 = alu_hs_cnt; m0 = out_hs_cnt;
    push_cmd(3'b000, 16'h1111, 16'h2222, acc);
    push_cmd(3'b011, 16'h00F0, 16'h000F, acc);
    wait_drain();
    check("nop_alu_count", 64'(alu_hs_cnt - n0), 64'd1);
    check("nop_out_count", 64'(out_hs_cnt - m0), 64'd1);

    // Output backpressure
    out_rdy_mode = 1;
    push_cmd(3'b001, 16'h0AB0, 16'h000C, acc);
    push_cmd(3'b010, 16'hF0F0, 16'h3C3C, acc);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge CLK);
      seen = (Out_Valid === 1'b1);
    end
    check("bp_out_valid", {63'd0, seen}, 64'd1);
    repeat (5) begin
      @(negedge CLK);
      check("bp_count", {61'd0, Count}, 64'd1);
      check("bp_no_alu", {63'd0, Alu_Valid}, 64'd0);
    end
    @(posedge CLK); #1;
    out_rdy_mode = 0;
    wait_drain();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      Enable = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      push_cmd(op, a, b, acc);
      repeat ($urandom_range(0, 4)) @(posedge CLK);
      #1;
    end
    wait_drain();

    // Reset while the ALU op is outstanding
    out_rdy_mode = 2;
    hold_done = 1'b1;
    n0 = alu_hs_cnt;
    push_cmd(3'b001, 16'h0001, 16'h0002, acc);
    push_cmd(3'b011, 16'h0F00, 16'h00F0, acc);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge CLK);
      seen = (alu_hs_cnt != n0);
    end
    check("wait_handshake", {63'd0, seen}, 64'd1);
    @(posedge CLK); #1;
    check("wait_state", {62'd0, Alu_Valid, Out_Valid}, 64'd0);
    do_reset(1);
    check("mid_rst_out_valid", {63'd0, Out_Valid}, 64'd0);
    check("mid_rst_alu_valid", {63'd0, Alu_Valid}, 64'd0);
    check("mid_rst_count", {61'd0, Count}, 64'd0);
    check("mid_rst_in_ready", {63'd0, In_Ready}, 64'd1);
    m0 = out_hs_cnt;
    repeat (8) @(posedge CLK);
    #1;
    check("mid_rst_no_retire", 64'(out_hs_cnt - m0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command issuer at the initiator end of the ALU operand/opcode interface. Buffers operations from a requester in a small FIFO, drives opcode and operands to the ALU with a valid/ready handshake, and waits for the ALU done strobe. Returns the result and carry to the requester. Keeps an accumulator register so that the write-to-A opcodes chain on the previous result.

Parameters:
WIDTH, 16, operand/result width
DEPTH, 4, command FIFO entries (power of 2, >=2)
CW, $clog2(DEPTH)+1, width of Count

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
Enable  in  1  permits popping/issuing new commands; in-flight op always completes
In_Valid  in  1  requester command valid
In_Ready  out  1  FIFO can accept
In_Opcode  in  3  operation code
In_A  in  WIDTH  operand A (ignored for opcodes 101-111)
In_B  in  WIDTH  operand B
Alu_Valid  out  1  command presented to ALU
Alu_Ready  in  1  ALU accepts command
Alu_Opcode  out  3  opcode to ALU
Alu_A  out  WIDTH  operand A to ALU
Alu_B  out  WIDTH  operand B to ALU
Alu_Done  in  1  one-cycle strobe: Alu_Result/Alu_CF valid
Alu_Result  in  WIDTH  ALU result
Alu_CF  in  1  ALU carry/overflow
Out_Valid  out  1  result available
Out_Ready  in  1  requester accepts result
Out_Opcode  out  3  opcode of retired op
Out_Result  out  WIDTH  result
Out_CF  out  1  carry of retired op
Count  out  CW  FIFO occupancy

Behaviour:
- Opcodes:
  - 000 NOP, 001 ADD, 010 AND, 011 OR, 100 SLT (unsigned A<B).
  - 101 ADDA, 110 ANDA, 111 ORA: Alu_A = Acc; In_A is ignored.
- Reset (RST=1 at an edge):
  - FIFO is emptied and pointers are zeroed; Count=0.
  - Acc=0; FSM goes to IDLE.
  - All outputs are 0 except In_Ready=1.
  - Reset mid-operation abandons the op. Alu_Valid and Out_Valid are 0 from the next cycle, and no Out transfer occurs for the abandoned op.
- FIFO:
  - Push when In_Valid && In_Ready; In_Ready = (Count < DEPTH), registered-count based.
  - No bypass: a pushed entry is visible one cycle later.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leave Count unchanged.
  - When full, In_Ready=0 even if a pop occurs in the same cycle.
- FSM states, all registered:
  - IDLE: if Enable && Count>0:
    - Head opcode NOP: pop; stay IDLE; no ALU activity and no output.
    - Otherwise: pop, latch opcode/A/B into issue registers (A replaced by Acc for 1x1/11x codes), go to ISSUE.
  - ISSUE: Alu_Valid=1 with stable Alu_Opcode/A/B. On Alu_Ready go to WAIT. Alu_Done in ISSUE is ignored.
  - WAIT: Alu_Valid=0. On Alu_Done:
    - Capture Alu_Result into Out_Result and Acc, and Alu_CF into Out_CF.
    - Go to RETIRE. There is no timeout.
  - RETIRE: Out_Valid=1 and outputs held stable until Out_Ready; then go to IDLE.
- Latency: push at cycle 0 -> IDLE pops at cycle 1 -> Alu_Valid at cycle 2. Out_Valid asserts the cycle after Alu_Done.
- Throughput: one op in flight; at most one op per 4 cycles.
- Enable=0:
  - No pop in IDLE.
  - ISSUE/WAIT/RETIRE proceed normally.
  - FIFO pushes are still accepted.
- Acc is updated only on Alu_Done in WAIT. NOPs do not alter Acc.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_NOP..OP_ORA (3-bit);
  - FSM state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_RETIRE;
  - default WIDTH.
- One sub-module: alu_cmd_fifo, a parameterised synchronous FIFO storing {opcode, A, B}, with push/pop/full/empty/count.

Test Plan:
1. Reset: RST=1 for 2 cycles, then 0 -> all outputs 0, In_Ready=1, Count=0, Alu_Valid=0.
2. Basic issue: push ADD A=0x0003 B=0x0004; ALU model Alu_Ready=1 and Alu_Done 2 cycles after handshake with 0x0007/CF=0 -> Alu_Valid at cycle 2 with 001/0x0003/0x0004; then Out_Valid with Out_Result=0x0007, Out_CF=0.
3. Accumulate: ADD 0xFFFF+0x0001 returns 0x0000/CF=1; then ADDA In_A=0x1234 B=0x0005 -> Alu_A=0x0000 (Acc, not 0x1234), Out_Result=0x0005.
4. Full FIFO: Enable=0, push 5 commands -> first 4 accepted, In_Ready=0 after the 4th, Count=4. Set Enable=1 -> 4 results retire in push order.
5. NOP drop: push NOP, then OR 0x00F0|0x000F -> single Alu_Valid (opcode 011), single Out_Valid with 0x00FF.
6. Backpressure/reset: Out_Ready=0 for 5 cycles -> Out_Valid and Out_Result stable, no new Alu_Valid. Then assert RST during a WAIT op -> next cycle Out_Valid=0, Count=0, no result retired.
